// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator constants: module numbers and debouncer states
package calc_pkg;

   localparam int MODE_ARITH    = 0;
   localparam int MODE_LOGIC    = 1;
   localparam int MODE_COMPARE  = 2;
   localparam int MODE_MAGIC    = 3;
   localparam int NUM_MODES_DEF = 4;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_e;

endpackage

// File: rtl/mode_select_input_key_debouncer.sv
// rtl/mode_select_input_key_debouncer.sv - per-key debouncer with a one-cycle press pulse
module key_debouncer
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic level_in,
   output logic level_out,
   output logic press_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   db_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            pulse_q, pulse_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   // The counter only advances while waiting, and the LAST compare stops it before it can wrap
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
         RELEASED: begin
            if (level_in) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!level_in) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!level_in) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (level_in) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      level_out   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
      press_pulse = pulse_q;
   end

endmodule

// File: rtl/mode_select_input.sv
// rtl/mode_select_input.sv - synchronised, debounced mode sequencer for the calculator front end
module mode_select_input
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2,
   parameter int NUM_MODES       = NUM_MODES_DEF
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [1:0] KEY,
   input  logic [9:0] SW,
   output logic [3:0] MODE_SEL,
   output logic [1:0] SUB_SEL,
   output logic [7:0] OPERAND,
   output logic       MODE_STEP,
   output logic [1:0] KEY_HELD
);

   localparam logic [3:0] MODE_FIRST = 4'(MODE_ARITH);
   localparam logic [3:0] MODE_LAST  = 4'(NUM_MODES - 1);

   logic [SYNC_STAGES-1:0][1:0] key_sync_q, key_sync_d;
   logic [SYNC_STAGES-1:0][9:0] sw_sync_q, sw_sync_d;
   logic [1:0]                  key_level;
   logic [1:0]                  press;
   logic [3:0]                  mode_sel_q, mode_sel_d;
   logic                        mode_step_q, mode_step_d;

   // Key stages reset to released (high) so reset release never looks like a press edge
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         key_sync_q  <= '1;
         sw_sync_q   <= '0;
         mode_sel_q  <= MODE_FIRST;
         mode_step_q <= 1'b0;
      end else begin
         key_sync_q  <= key_sync_d;
         sw_sync_q   <= sw_sync_d;
         mode_sel_q  <= mode_sel_d;
         mode_step_q <= mode_step_d;
      end
   end

   always_comb begin
      key_sync_d = {key_sync_q[SYNC_STAGES-2:0], KEY};
      sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], SW};
      key_level  = ~key_sync_q[SYNC_STAGES-1];
   end

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .level_in    (key_level[0]),
      .level_out   (KEY_HELD[0]),
      .press_pulse (press[0])
   );

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .level_in    (key_level[1]),
      .level_out   (KEY_HELD[1]),
      .press_pulse (press[1])
   );

   // Coincident forward and backward presses cancel out
   always_comb begin
      mode_sel_d  = mode_sel_q;
      mode_step_d = 1'b0;
      if (press[0] && !press[1]) begin
         mode_sel_d  = (mode_sel_q == MODE_LAST) ? MODE_FIRST : mode_sel_q + 4'd1;
         mode_step_d = 1'b1;
      end else if (press[1] && !press[0]) begin
         mode_sel_d  = (mode_sel_q == MODE_FIRST) ? MODE_LAST : mode_sel_q - 4'd1;
         mode_step_d = 1'b1;
      end
   end

   always_comb begin
      MODE_SEL  = mode_sel_q;
      MODE_STEP = mode_step_q;
      SUB_SEL   = sw_sync_q[SYNC_STAGES-1][9:8];
      OPERAND   = sw_sync_q[SYNC_STAGES-1][7:0];
   end

endmodule

// File: tb/tb_mode_select_input.sv
// tb/tb_mode_select_input.sv - directed table-driven bench for mode_select_input
module tb_mode_select_input;

   logic       CLK;
   logic       RST_N;
   logic [1:0] KEY;
   logic [9:0] SW;
   logic [3:0] MODE_SEL;
   logic [1:0] SUB_SEL;
   logic [7:0] OPERAND;
   logic       MODE_STEP;
   logic [1:0] KEY_HELD;

   int n_cmp;
   int n_fail;

   mode_select_input #(
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2),
      .NUM_MODES       (4)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .KEY       (KEY),
      .SW        (SW),
      .MODE_SEL  (MODE_SEL),
      .SUB_SEL   (SUB_SEL),
      .OPERAND   (OPERAND),
      .MODE_STEP (MODE_STEP),
      .KEY_HELD  (KEY_HELD)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [9:0] sw;
      logic [1:0] sub;
      logic [7:0] op;
   } swvec_t;

   typedef struct {
      logic [1:0] keys;
      logic [3:0] exp_mode;
      int         exp_steps;
      logic [1:0] exp_held;
   } mvec_t;

   swvec_t swtab[3];
   mvec_t  mtab[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Advance n cycles, counting MODE_STEP pulses and OR-ing KEY_HELD
   task automatic run(input int n, output int steps, output logic [1:0] held_any);
      steps    = 0;
      held_any = 2'b00;
      for (int i = 0; i < n; i++) begin
         tick(1);
         if (MODE_STEP) steps++;
         held_any |= KEY_HELD;
      end
   endtask

   initial begin
      int         steps;
      int         steps2;
      logic [1:0] held_any;
      logic [7:0] prev_op;
      logic [1:0] prev_sub;

      n_cmp  = 0;
      n_fail = 0;

      swtab[0] = '{10'h2A5, 2'b10, 8'hA5};
      swtab[1] = '{10'h3FF, 2'b11, 8'hFF};
      swtab[2] = '{10'h100, 2'b01, 8'h00};

      // Mode starts at 2 when the table runs
      mtab[0] = '{2'b01, 4'd3, 1, 2'b01};
      mtab[1] = '{2'b01, 4'd0, 1, 2'b01};
      mtab[2] = '{2'b01, 4'd1, 1, 2'b01};
      mtab[3] = '{2'b01, 4'd2, 1, 2'b01};
      mtab[4] = '{2'b01, 4'd3, 1, 2'b01};
      mtab[5] = '{2'b01, 4'd0, 1, 2'b01};
      mtab[6] = '{2'b10, 4'd3, 1, 2'b10};
      mtab[7] = '{2'b10, 4'd2, 1, 2'b10};
      mtab[8] = '{2'b11, 4'd2, 0, 2'b11};
      mtab[9] = '{2'b10, 4'd1, 1, 2'b10};

      RST_N = 1'b0;
      KEY   = 2'b11;
      SW    = 10'h3C3;
      #2;
      check("rst_mode", MODE_SEL, 4'd0);
      check("rst_step", MODE_STEP, 1'b0);
      check("rst_held", KEY_HELD, 2'b00);
      check("rst_operand", OPERAND, 8'h00);
      check("rst_sub", SUB_SEL, 2'b00);
      tick(3);
      RST_N = 1'b1;
      tick(2);

      prev_op  = OPERAND;
      prev_sub = SUB_SEL;
      for (int i = 0; i < 3; i++) begin
         SW = swtab[i].sw;
         tick(1);
         check("sw_operand_early", OPERAND, prev_op);
         check("sw_sub_early", SUB_SEL, prev_sub);
         tick(1);
         check("sw_operand", OPERAND, swtab[i].op);
         check("sw_sub", SUB_SEL, swtab[i].sub);
         prev_op  = swtab[i].op;
         prev_sub = swtab[i].sub;
      end

      // Clean press: KEY[0] falls in cycle 0, held level and pulse in cycle 6, step in cycle 7
      KEY = 2'b10;
      tick(5);
      check("press_held_c5", KEY_HELD, 2'b00);
      tick(1);
      check("press_held_c6", KEY_HELD, 2'b01);
      check("press_step_c6", MODE_STEP, 1'b0);
      check("press_mode_c6", MODE_SEL, 4'd0);
      tick(1);
      check("press_step_c7", MODE_STEP, 1'b1);
      check("press_mode_c7", MODE_SEL, 4'd1);
      tick(1);
      check("press_step_c8", MODE_STEP, 1'b0);
      run(12, steps, held_any);
      KEY = 2'b11;
      run(12, steps2, held_any);
      check("press_extra_steps", steps + steps2, 0);
      check("press_mode_after", MODE_SEL, 4'd1);
      check("press_release_held", KEY_HELD, 2'b00);

      // Bounce: 3-cycle glitches never qualify
      for (int i = 0; i < 5; i++) begin
         KEY = 2'b10;
         run(3, steps, held_any);
         check("bounce_held_lo", held_any, 2'b00);
         check("bounce_steps_lo", steps, 0);
         KEY = 2'b11;
         run(3, steps, held_any);
         check("bounce_held_hi", held_any, 2'b00);
      end
      KEY = 2'b10;
      run(20, steps, held_any);
      KEY = 2'b11;
      run(10, steps2, held_any);
      check("bounce_steps", steps + steps2, 1);
      check("bounce_mode", MODE_SEL, 4'd2);

      for (int i = 0; i < 10; i++) begin
         KEY = ~mtab[i].keys;
         run(10, steps, held_any);
         check("tab_held", KEY_HELD, mtab[i].exp_held);
         run(10, steps2, held_any);
         steps += steps2;
         KEY = 2'b11;
         run(10, steps2, held_any);
         steps += steps2;
         check("tab_steps", steps, mtab[i].exp_steps);
         check("tab_mode", MODE_SEL, mtab[i].exp_mode);
      end

      // Reset in the middle of PRESS_WAIT, key released during reset: no step
      KEY = 2'b10;
      tick(4);
      RST_N = 1'b0;
      tick(1);
      check("midrst_mode", MODE_SEL, 4'd0);
      KEY = 2'b11;
      tick(1);
      RST_N = 1'b1;
      run(20, steps, held_any);
      check("midrst_steps", steps, 0);
      check("midrst_held", held_any, 2'b00);
      check("midrst_mode_after", MODE_SEL, 4'd0);

      // Async reset mid-cycle with key held and random switches, then the held key re-presses
      KEY = 2'b10;
      SW  = 10'($urandom);
      run(12, steps, held_any);
      check("async_pre_mode", MODE_SEL, 4'd1);
      check("async_pre_held", KEY_HELD, 2'b01);
      #2;
      RST_N = 1'b0;
      #1;
      check("async_mode", MODE_SEL, 4'd0);
      check("async_step", MODE_STEP, 1'b0);
      check("async_held", KEY_HELD, 2'b00);
      check("async_operand", OPERAND, 8'h00);
      check("async_sub", SUB_SEL, 2'b00);
      tick(2);
      RST_N = 1'b1;
      run(20, steps, held_any);
      check("repress_steps", steps, 1);
      check("repress_mode", MODE_SEL, 4'd1);
      KEY = 2'b11;
      tick(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
